// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer:
//   - state_e     : controller states (IDLE, WRITE, READ)
//   - ERR_*       : bit positions inside the sticky error register
//   - WORD_STRIDE : byte distance between two stacked words
//   - err_mask()  : one-hot mask for an error bit index
package stack_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;
  localparam int unsigned ERR_ILL = 2;
  localparam int unsigned ERR_TMO = 3;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  // One-hot mask selecting a single error flag.
  function automatic logic [3:0] err_mask(input int unsigned idx);
    err_mask = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Decode/memory bus of the stack sequencer.
//   master : the sequencer (takes requests, drives memory strobes and status)
//   slave  : the environment (decode stage + data memory)
// Signals:
//   push_req/pop_req/push_data : decode request and push value
//   mem_ready/mem_rdata        : memory handshake and read data
//   err_clr                    : clears the sticky error register
//   mem_addr/mem_wdata/mem_we/mem_re : memory access
//   stall                      : pipeline freeze
//   pop_data/pop_valid         : popped value and its one-cycle valid
//   sp/err                     : stack pointer and sticky error flags
interface stack_sequencer_if;
  logic        push_req;
  logic        pop_req;
  logic [31:0] push_data;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err_clr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        stall;
  logic [31:0] pop_data;
  logic        pop_valid;
  logic [31:0] sp;
  logic [3:0]  err;

  modport master (
    input  push_req, pop_req, push_data, mem_ready, mem_rdata, err_clr,
    output mem_addr, mem_wdata, mem_we, mem_re, stall, pop_data, pop_valid, sp, err
  );

  modport slave (
    output push_req, pop_req, push_data, mem_ready, mem_rdata, err_clr,
    input  mem_addr, mem_wdata, mem_we, mem_re, stall, pop_data, pop_valid, sp, err
  );
endinterface

// File: rtl/stack_sequencer_wait_timer.sv
// Wait timer for a memory access.
// Up-counter with clear, load and enable. o_expired flags the cycle whose
// increment makes the count reach TIMEOUT, i.e. TIMEOUT cycles have now
// passed without the awaited event.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   i_clr          : synchronous clear (highest priority)
//   i_load/i_load_val : synchronous load
//   i_en           : count this cycle
//   o_expired      : this enabled cycle completes TIMEOUT counted cycles
module stack_sequencer_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_expired
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter; saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/stack_sequencer.sv
// Stack sequencer: executes PUSH/POP requests from decode against data
// memory as a full-descending stack. One memory write (push) or read (pop)
// per request, completed over the mem_ready handshake; the pipeline is
// frozen while an access is outstanding. Overflow, underflow, illegal
// (simultaneous push+pop) and timeout conditions are kept in a sticky
// error register.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : stack_sequencer_if.master (requests, memory bus, status)
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter logic [31:0] STACK_BASE = 32'h0000_1000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  stack_sequencer_if.master bus
);

  localparam int unsigned    CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam int unsigned    TW       = $clog2(TIMEOUT + 1);

  state_e           r_state;
  logic [31:0]      r_sp;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_mem_we;
  logic             r_mem_re;
  logic [31:0]      r_pop_data;
  logic             r_pop_valid;
  logic [3:0]       r_err;

  logic       w_idle;
  logic       w_full;
  logic       w_empty;
  logic       w_both;
  logic       w_start_push;
  logic       w_start_pop;
  logic       w_start;
  logic       w_wait_en;
  logic       w_timeout;
  logic [3:0] w_err_set;
  logic [3:0] w_err_next;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_both  = bus.push_req && bus.pop_req;

  // Only a single, legal request in IDLE starts an access.
  assign w_start_push = w_idle && bus.push_req && !bus.pop_req && !w_full;
  assign w_start_pop  = w_idle && bus.pop_req && !bus.push_req && !w_empty;
  assign w_start      = w_start_push || w_start_pop;

  // Count only cycles of an outstanding access that lack mem_ready.
  assign w_wait_en = !w_idle && !bus.mem_ready;

  stack_sequencer_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start),
    .i_load     (1'b0),
    .i_load_val ({TW{1'b0}}),
    .i_en       (w_wait_en),
    .o_expired  (w_timeout)
  );

  // Error flags raised this cycle and next sticky value; new errors beat err_clr.
  always_comb begin
    w_err_set = 4'b0000;
    if (w_idle) begin
      if (w_both) begin
        w_err_set = err_mask(ERR_ILL);
      end else if (bus.push_req && w_full) begin
        w_err_set = err_mask(ERR_OVF);
      end else if (bus.pop_req && w_empty) begin
        w_err_set = err_mask(ERR_UNF);
      end else begin
        w_err_set = 4'b0000;
      end
    end else if (w_timeout) begin
      w_err_set = err_mask(ERR_TMO);
    end else begin
      w_err_set = 4'b0000;
    end
    w_err_next = (bus.err_clr ? 4'b0000 : r_err) | w_err_set;
  end

  // Access FSM with registered strobes, stack pointer, count and pop result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_sp        <= STACK_BASE;
      r_count     <= '0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_pop_data  <= 32'h0000_0000;
      r_pop_valid <= 1'b0;
      r_err       <= 4'b0000;
    end else begin
      r_pop_valid <= 1'b0;
      r_err       <= w_err_next;
      case (r_state)
        ST_IDLE: begin
          if (w_start_push) begin
            // Full-descending: the new word goes just below the current top.
            r_mem_addr  <= r_sp - WORD_STRIDE;
            r_mem_wdata <= bus.push_data;
            r_mem_we    <= 1'b1;
            r_state     <= ST_WRITE;
          end else if (w_start_pop) begin
            r_mem_addr <= r_sp;
            r_mem_re   <= 1'b1;
            r_state    <= ST_READ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (bus.mem_ready) begin
            r_sp     <= r_sp - WORD_STRIDE;
            r_count  <= r_count + CNT_W'(1);
            r_mem_we <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_timeout) begin
            // Abandon the access; stack state stays as it was.
            r_mem_we <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_state <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (bus.mem_ready) begin
            r_pop_data  <= bus.mem_rdata;
            r_pop_valid <= 1'b1;
            r_sp        <= r_sp + WORD_STRIDE;
            r_count     <= r_count - CNT_W'(1);
            r_mem_re    <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_timeout) begin
            r_mem_re <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_state <= ST_READ;
          end
        end
        default: begin
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall in the request cycle too, so the PC never moves past the PUSH/POP.
  assign bus.stall     = !w_idle || w_start;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.pop_data  = r_pop_data;
  assign bus.pop_valid = r_pop_valid;
  assign bus.sp        = r_sp;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios plus a
// randomized push/pop/illegal/clear mix checked against a queue-based
// stack model and a behavioural data memory.
module tb_stack_sequencer;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_sequencer_if bif ();
  stack_sequencer_if tif ();

  stack_sequencer #(.DEPTH(DEPTH), .STACK_BASE(BASE), .TIMEOUT(255)) u_dut (
    .clk (clk), .rst (rst), .bus (bif.master)
  );

  stack_sequencer #(.DEPTH(DEPTH), .STACK_BASE(BASE), .TIMEOUT(3)) u_tmo (
    .clk (clk), .rst (rst), .bus (tif.master)
  );

  int vecs = 0;
  int miss = 0;

  logic [31:0] m_q[$];
  logic [3:0]  m_err;
  logic [31:0] mem[logic [31:0]];

  function automatic logic [31:0] exp_sp();
    return BASE - 32'(4 * m_q.size());
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] d, input int dly);
    int st;
    st = 0;
    bif.push_req = 1'b1; bif.push_data = d; bif.mem_ready = 1'b0;
    #3;
    if (m_q.size() == DEPTH) begin
      chk("ovf_stall", 32'(bif.stall), 32'd0);
      tick();
      bif.push_req = 1'b0;
      m_err[0] = 1'b1;
      #3;
      chk("ovf_err", 32'(bif.err), 32'(m_err));
      chk("ovf_we", 32'(bif.mem_we), 32'd0);
      chk("ovf_sp", bif.sp, exp_sp());
      tick();
    end else begin
      chk("push_stall", 32'(bif.stall), 32'd1);
      st = 1;
      tick();
      for (int k = 0; k <= dly; k++) begin
        bif.mem_ready = (k == dly);
        #3;
        chk("push_we", 32'(bif.mem_we), 32'd1);
        chk("push_addr", bif.mem_addr, exp_sp() - 32'd4);
        chk("push_wdata", bif.mem_wdata, d);
        if (bif.stall) st++;
        if (k == dly) mem[bif.mem_addr] = bif.mem_wdata;
        tick();
      end
      bif.push_req = 1'b0; bif.mem_ready = 1'b0;
      m_q.push_front(d);
      #3;
      chk("push_done_stall", 32'(bif.stall), 32'd0);
      chk("push_done_we", 32'(bif.mem_we), 32'd0);
      chk("push_sp", bif.sp, exp_sp());
      chk("push_stall_cycles", 32'(st), 32'(dly + 2));
      tick();
    end
  endtask

  task automatic do_pop(input int dly);
    logic [31:0] exp_d;
    bif.pop_req = 1'b1; bif.mem_ready = 1'b0;
    #3;
    if (m_q.size() == 0) begin
      chk("unf_stall", 32'(bif.stall), 32'd0);
      tick();
      bif.pop_req = 1'b0;
      m_err[1] = 1'b1;
      #3;
      chk("unf_err", 32'(bif.err), 32'(m_err));
      chk("unf_re", 32'(bif.mem_re), 32'd0);
      chk("unf_valid", 32'(bif.pop_valid), 32'd0);
      tick();
    end else begin
      exp_d = m_q[0];
      chk("pop_stall", 32'(bif.stall), 32'd1);
      tick();
      for (int k = 0; k <= dly; k++) begin
        bif.mem_ready = (k == dly);
        bif.mem_rdata = (k == dly) ? mem_rd(bif.mem_addr) : 32'h0000_0000;
        #3;
        chk("pop_re", 32'(bif.mem_re), 32'd1);
        chk("pop_addr", bif.mem_addr, exp_sp());
        chk("pop_early_valid", 32'(bif.pop_valid), 32'd0);
        tick();
      end
      bif.pop_req = 1'b0; bif.mem_ready = 1'b0;
      void'(m_q.pop_front());
      #3;
      chk("pop_valid", 32'(bif.pop_valid), 32'd1);
      chk("pop_data", bif.pop_data, exp_d);
      chk("pop_sp", bif.sp, exp_sp());
      chk("pop_done_re", 32'(bif.mem_re), 32'd0);
      chk("pop_done_stall", 32'(bif.stall), 32'd0);
      tick();
      #3;
      chk("pop_valid_pulse", 32'(bif.pop_valid), 32'd0);
      tick();
    end
  endtask

  task automatic do_illegal(input logic clr);
    bif.push_req = 1'b1; bif.pop_req = 1'b1; bif.err_clr = clr;
    bif.push_data = $urandom;
    #3;
    chk("ill_stall", 32'(bif.stall), 32'd0);
    tick();
    bif.push_req = 1'b0; bif.pop_req = 1'b0; bif.err_clr = 1'b0;
    m_err = (clr ? 4'b0000 : m_err) | 4'b0100;
    #3;
    chk("ill_err", 32'(bif.err), 32'(m_err));
    chk("ill_we", 32'(bif.mem_we), 32'd0);
    chk("ill_re", 32'(bif.mem_re), 32'd0);
    chk("ill_sp", bif.sp, exp_sp());
    tick();
  endtask

  task automatic do_clr();
    bif.err_clr = 1'b1;
    tick();
    bif.err_clr = 1'b0;
    m_err = 4'b0000;
    #3;
    chk("clr_err", 32'(bif.err), 32'd0);
    tick();
  endtask

  initial begin
    int r;
    bif.push_req = 1'b0; bif.pop_req = 1'b0; bif.push_data = 32'd0;
    bif.mem_ready = 1'b0; bif.mem_rdata = 32'd0; bif.err_clr = 1'b0;
    tif.push_req = 1'b0; tif.pop_req = 1'b0; tif.push_data = 32'd0;
    tif.mem_ready = 1'b0; tif.mem_rdata = 32'd0; tif.err_clr = 1'b0;
    m_err = 4'b0000;

    // Reset values
    tick(); tick();
    #3;
    chk("rst_sp", bif.sp, BASE);
    chk("rst_addr", bif.mem_addr, 32'd0);
    chk("rst_wdata", bif.mem_wdata, 32'd0);
    chk("rst_pop_data", bif.pop_data, 32'd0);
    chk("rst_strobes", {28'd0, bif.mem_we, bif.mem_re, bif.pop_valid, bif.stall}, 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    chk("rst_tmo_sp", tif.sp, BASE);
    tick();
    rst = 1'b1;
    tick();

    // Push then pop with ready at the first access cycle
    do_push(32'hDEAD_BEEF, 0);
    chk("pp_sp_push", bif.sp, 32'h0000_0FFC);
    do_pop(0);
    chk("pp_sp_pop", bif.sp, 32'h0000_1000);

    // Underflow, illegal, clear, and error raised alongside clear
    do_pop(0);
    chk("unf_only", 32'(bif.err), 32'h0000_0002);
    do_clr();
    do_illegal(1'b0);
    chk("ill_only", 32'(bif.err), 32'h0000_0004);
    do_clr();
    do_pop(0);
    do_illegal(1'b1);
    chk("ill_beats_clr", 32'(bif.err), 32'h0000_0004);
    do_clr();

    // Delayed ready: ready five cycles after the request -> six stalled cycles
    do_push(32'h1234_5678, 4);
    do_pop(3);

    // Fill to capacity, then one more
    for (int i = 0; i < DEPTH; i++) do_push($urandom, 0);
    do_push(32'hCAFE_F00D, 0);
    chk("fill_err", 32'(bif.err), 32'h0000_0001);
    chk("fill_sp", bif.sp, BASE - 32'd256);
    do_clr();

    // Randomized mix
    for (int i = 0; i < 220; i++) begin
      r = $urandom_range(0, 19);
      if (r < 8) do_push($urandom, $urandom_range(0, 3));
      else if (r < 17) do_pop($urandom_range(0, 3));
      else if (r < 19) do_illegal(1'($urandom_range(0, 1)));
      else do_clr();
    end

    // Timeout on the TIMEOUT=3 instance: three strobe cycles, then give up
    tif.push_req = 1'b1; tif.push_data = 32'hA5A5_5A5A;
    #3;
    chk("tmo_req_stall", 32'(tif.stall), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("tmo_we", 32'(tif.mem_we), 32'd1);
      chk("tmo_addr", tif.mem_addr, BASE - 32'd4);
      chk("tmo_wdata", tif.mem_wdata, 32'hA5A5_5A5A);
      tick();
    end
    tif.push_req = 1'b0;
    #3;
    chk("tmo_we_drop", 32'(tif.mem_we), 32'd0);
    chk("tmo_err", 32'(tif.err), 32'h0000_0008);
    chk("tmo_sp", tif.sp, BASE);
    chk("tmo_stall", 32'(tif.stall), 32'd0);
    tick();

    // Reset asserted during a READ
    do_push(32'h0BAD_CAFE, 0);
    do_push(32'h600D_F00D, 0);
    bif.pop_req = 1'b1; bif.mem_ready = 1'b0;
    tick();
    #3;
    chk("mid_re", 32'(bif.mem_re), 32'd1);
    bif.pop_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_sp", bif.sp, BASE);
    chk("mid_addr", bif.mem_addr, 32'd0);
    chk("mid_wdata", bif.mem_wdata, 32'd0);
    chk("mid_pop_data", bif.pop_data, 32'd0);
    chk("mid_strobes", {28'd0, bif.mem_we, bif.mem_re, bif.pop_valid, bif.stall}, 32'd0);
    chk("mid_err", 32'(bif.err), 32'd0);
    #2;
    rst = 1'b1;
    m_q.delete();
    m_err = 4'b0000;
    tick();
    do_pop(0);
    chk("post_rst_unf", 32'(bif.err), 32'h0000_0002);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle controller that executes the PUSH/POP instructions flagged by the decode stage against data memory. It owns the stack pointer and sequences one memory write (push) or read (pop) per request over a ready handshake. It freezes the PC/pipeline while the access is outstanding and records overflow, underflow, illegal and timeout errors in a sticky register.

## Interface
- `DEPTH`, 64: stack capacity in 32-bit words (power of two, ≥2).
- `STACK_BASE`, 32'h0000_1000: reset value of `sp`; the stack is empty when `sp` equals this value.
- `TIMEOUT`, 255: maximum number of cycles to wait for `mem_ready` (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `push_req` in 1: decode requests PUSH; held stable while `stall`=1.
- `pop_req` in 1: decode requests POP; held stable while `stall`=1.
- `push_data` in 32: value to push (register-file read data).
- `mem_ready` in 1: memory has accepted the write or delivered the read data this cycle.
- `mem_rdata` in 32: read data, valid when `mem_ready`=1 during a read.
- `err_clr` in 1: clears `err`.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_we` out 1: memory write strobe.
- `mem_re` out 1: memory read strobe.
- `stall` out 1: high freezes PC/pipeline (drives PCWrite low).
- `pop_data` out 32: popped value.
- `pop_valid` out 1: one-cycle pulse; `pop_data` is valid.
- `sp` out 32: current stack pointer.
- `err` out 4: sticky error flags {timeout, illegal, underflow, overflow}.

## Operation
- Full-descending stack. `count` runs 0..DEPTH, with `$clog2(DEPTH)+1` bits.
- FSM states: IDLE, WRITE, READ.
- In IDLE, requests are sampled each cycle:
  - `push_req` & `pop_req`: nothing executes; set `err[2]`; no stall.
  - `push_req` with `count`==DEPTH: set `err[0]`; no access; no stall.
  - `push_req` otherwise: latch `mem_addr`=`sp`-4 and `mem_wdata`=`push_data`; go to WRITE.
  - `pop_req` with `count`==0: set `err[1]`; no access; no stall; no `pop_valid`.
  - `pop_req` otherwise: latch `mem_addr`=`sp`; go to READ.
- WRITE: `mem_we`=1 until `mem_ready`. On `mem_ready`: `sp`-=4, `count`+=1, go to IDLE.
- READ: `mem_re`=1 until `mem_ready`. On `mem_ready`: `pop_data`<=`mem_rdata`, `pop_valid`=1 for one cycle, `sp`+=4, `count`-=1, go to IDLE.
- Wait counter: cleared on entry to WRITE/READ and incremented each cycle without `mem_ready`.
  - When it reaches TIMEOUT with no ready: set `err[3]`, drop the strobe, go to IDLE.
  - `sp`, `count` and `pop_data` are left unchanged.
- `err` bits are sticky. `err_clr` clears them, but an error raised in the same cycle wins.
- `sp` arithmetic is modulo 2^32; address alignment is the requester's responsibility.

## Timing
- `stall` is combinational: high when state≠IDLE, or when in IDLE with a request that will start an access. The pipeline therefore freezes in the request cycle.
- Push latency: request at cycle 0, WRITE from cycle 1. With `mem_ready` at cycle 1, `sp` updates at the end of cycle 1 and `stall` is low in cycle 2. Best case is 2 stalled cycles.
- Pop: `pop_valid` and `pop_data` are registered and appear in the cycle after `mem_ready`; the FSM is already in IDLE in that cycle.
- Requests arriving while not in IDLE are ignored.
- `mem_addr` and `mem_wdata` are registered and stable for the whole access.
- Reset values:
  - state IDLE; `sp`=STACK_BASE; `count`=0.
  - `mem_addr`, `mem_wdata` and `pop_data` = 0.
  - `mem_we`, `mem_re`, `pop_valid` and `stall` = 0; `err`=0.
- Reset asserted mid-access aborts immediately with no state update and drops the strobes.

## Structure
- Shared package holds:
  - the state enum (IDLE, WRITE, READ);
  - error bit index constants (ERR_OVF=0, ERR_UNF=1, ERR_ILL=2, ERR_TMO=3);
  - the word stride constant 4.
- Sub-module `wait_timer`: a loadable up-counter with clear, enable and `expired` compare against TIMEOUT.
- Everything else sits in one module.

## Test plan
- **Push then pop:** push 32'hDEAD_BEEF with `mem_ready` tied high → write to 0x0FFC and `sp`=0x0FFC. Then pop → read 0x0FFC, `pop_data`=DEAD_BEEF, `sp`=0x1000, `pop_valid` one cycle.
- **Fill to capacity:** 64 pushes, then a 65th → `err`=4'b0001, no `mem_we`, `sp`=STACK_BASE-256, `stall` never high for the 65th.
- **Underflow:** pop after reset → `err`=4'b0010, no `mem_re`, no `pop_valid`.
- **Illegal request:** `push_req`=`pop_req`=1 in IDLE → `err`=4'b0100, no access. Then `err_clr` → `err`=0.
- **Delayed ready:** push with `mem_ready` delayed 5 cycles → `stall` high for 6 cycles and `mem_we` steady with the same address/data. With TIMEOUT=3 and no ready → `err[3]`=1, `sp` unchanged.
- **Reset mid-access:** assert `rst` low during READ → all outputs return to reset values immediately; the next pop reports underflow.
